// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph: memory-mapped peripheral block for the MEM stage.
//   Holds a 32-bit reload timer (TH reload, TL count, TCON control), an LED latch, a 7-seg digit
//   latch and a free-running SYSTICK counter in a 6-word window at BASE_ADDR.
// Ports:
//   clk, reset     system clock; synchronous active-high reset
//   rd, wr         MEM-stage read / write enables
//   addr, wdata    byte address and write data from the MEM stage
//   rdata          combinational read data (0 unless rd & hit)
//   hit            addr lies in the register window
//   led, digi      LED and 7-seg register outputs
//   irq            level interrupt request: TCON[1] & TCON[2]
module mmio_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  localparam logic [2:0] OffTh   = 3'd0;
  localparam logic [2:0] OffTl   = 3'd1;
  localparam logic [2:0] OffTcon = 3'd2;
  localparam logic [2:0] OffLed  = 3'd3;
  localparam logic [2:0] OffDigi = 3'd4;
  localparam logic [2:0] OffTick = 3'd5;

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [31:0]       systick_q, systick_d;

  logic [2:0] offset;
  logic       wr_hit;
  logic       tl_wr;
  logic       ovf;
  logic       ovf_set;

  // Byte lane bits are not decoded.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign offset = addr[4:2];
  assign hit    = (addr[31:5] == BASE_ADDR[31:5]) && (offset <= OffTick);
  assign wr_hit = wr && hit;
  assign tl_wr  = wr_hit && (offset == OffTl);

  // A software TL write in the same cycle cancels the overflow entirely.
  assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set = ovf && !tl_wr && tcon_q[1];

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = {tcon_q[2] | ovf_set, tcon_q[1:0]};
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tl_wr) begin
      tl_d = wdata;
    end else if (tcon_q[0]) begin
      // Reload always uses the pre-edge TH, even if TH is written this cycle.
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end

    if (wr_hit) begin
      case (offset)
        OffTh:   th_d   = wdata;
        // A status clear never drops an overflow landing on the same edge.
        OffTcon: tcon_d = {wdata[2] | ovf_set, wdata[1:0]};
        OffLed:  led_d  = wdata[LED_W-1:0];
        OffDigi: digi_d = wdata[DIGI_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (offset)
        OffTh:   rdata = th_q;
        OffTl:   rdata = tl_q;
        OffTcon: rdata = {29'h0, tcon_q};
        OffLed:  rdata = {{(32 - LED_W){1'b0}}, led_q};
        OffDigi: rdata = {{(32 - DIGI_W){1'b0}}, digi_q};
        OffTick: rdata = systick_q;
        default: rdata = 32'h0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;
  assign irq  = tcon_q[1] & tcon_q[2];

endmodule
